// File: rtl/pdp8_pkg.sv
// PDP-8 instruction field types, opcode constants and the shared word decoder.
// Used by the instruction feeder and by anything that needs the same decode.
package pdp8_pkg;

   localparam int ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 12;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_TAD = 3'd1;
   localparam logic [2:0] OP_ISZ = 3'd2;
   localparam logic [2:0] OP_DCA = 3'd3;
   localparam logic [2:0] OP_JMS = 3'd4;
   localparam logic [2:0] OP_JMP = 3'd5;
   localparam logic [2:0] OP_IOT = 3'd6;
   localparam logic [2:0] OP_OPR = 3'd7;

   typedef struct packed {
      logic indirect;
      logic and_op;
      logic tad;
      logic isz;
      logic dca;
      logic jms;
      logic jmp;
   } pdp_mem_opcode_s;

   typedef struct packed {
      logic cla;
      logic cll;
      logic cma;
      logic cml;
      logic rar;
      logic ral;
      logic twice;
      logic iac;
      logic sma;
      logic sza;
      logic snl;
      logic skip_rev;
      logic osr;
      logic hlt;
   } pdp_op7_opcode_s;

   typedef struct packed {
      logic            supported;
      pdp_mem_opcode_s mem;
      pdp_op7_opcode_s op7;
      logic [11:0]     base_addr;
   } decode_s;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } feeder_state_e;

   // IOT and group-3 operate words come back with supported=0 and all fields clear.
   function automatic decode_s decode_word(input logic [11:0] word, input logic [11:0] pc);
      decode_s d;
      d = '0;
      case (word[11:9])
         OP_AND, OP_TAD, OP_ISZ, OP_DCA, OP_JMS, OP_JMP: begin
            d.supported    = 1'b1;
            d.mem.indirect = word[8];
            case (word[11:9])
               OP_AND:  d.mem.and_op = 1'b1;
               OP_TAD:  d.mem.tad    = 1'b1;
               OP_ISZ:  d.mem.isz    = 1'b1;
               OP_DCA:  d.mem.dca    = 1'b1;
               OP_JMS:  d.mem.jms    = 1'b1;
               default: d.mem.jmp    = 1'b1;
            endcase
            d.base_addr = word[7] ? {pc[11:7], word[6:0]} : {5'b0, word[6:0]};
         end
         OP_OPR: begin
            if (!word[8]) begin
               d.supported = 1'b1;
               d.op7.cla   = word[7];
               d.op7.cll   = word[6];
               d.op7.cma   = word[5];
               d.op7.cml   = word[4];
               d.op7.rar   = word[3];
               d.op7.ral   = word[2];
               d.op7.twice = word[1];
               d.op7.iac   = word[0];
            end else if (!word[0]) begin
               d.supported    = 1'b1;
               d.op7.cla      = word[7];
               d.op7.sma      = word[6];
               d.op7.sza      = word[5];
               d.op7.snl      = word[4];
               d.op7.skip_rev = word[3];
               d.op7.osr      = word[2];
               d.op7.hlt      = word[1];
            end
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// Synchronous FIFO with asynchronous reset; head is the registered oldest entry,
// so a word written at one edge can be read no earlier than the next.
module instr_word_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/exec_instr_feeder.sv
// Instruction-issue front end for instr_exec: queues raw PDP-8 words, decodes
// them and presents each for one cycle under the exec stall handshake.
module exec_instr_feeder
   import pdp8_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_WIDTH = pdp8_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = pdp8_pkg::DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          load_valid,
   input  logic [DATA_WIDTH-1:0]         load_data,
   output logic                          load_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   input  logic                          stall,
   input  logic [ADDR_WIDTH-1:0]         PC_value,
   output logic [ADDR_WIDTH-1:0]         base_addr,
   output pdp_mem_opcode_s               pdp_mem_opcode,
   output pdp_op7_opcode_s               pdp_op7_opcode,
   output logic                          issue_pulse,
   output logic [15:0]                   issued_count,
   output logic [7:0]                    unsupported_count,
   output logic                          halted,
   output logic                          overflow,
   output feeder_state_e                 fsm_state
);

   // Handshake: a word is accepted on any edge where load_valid && load_ready;
   // load_valid while not ready is dropped and recorded in overflow. Issue is a
   // one-cycle issue_pulse with the decoded fields; exec holds stall high while busy.

   feeder_state_e          state;
   logic [DATA_WIDTH-1:0]  head;
   logic                   full;
   logic                   empty;
   logic                   pop;
   decode_s                dec;

   assign load_ready = !full;
   assign fsm_state  = state;
   assign pop        = (state == ST_IDLE) && !empty && !stall && !halted;
   assign dec        = decode_word(head, PC_value);

   instr_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (load_valid),
      .push_data (load_data),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         base_addr         <= '0;
         pdp_mem_opcode    <= '0;
         pdp_op7_opcode    <= '0;
         issue_pulse       <= 1'b0;
         issued_count      <= '0;
         unsupported_count <= '0;
         halted            <= 1'b0;
         overflow          <= 1'b0;
      end else begin
         if (load_valid && full) overflow <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  if (dec.supported) begin
                     base_addr      <= dec.base_addr;
                     pdp_mem_opcode <= dec.mem;
                     pdp_op7_opcode <= dec.op7;
                     issue_pulse    <= 1'b1;
                     state          <= ST_ISSUE;
                     if (issued_count != '1) issued_count <= issued_count + 1'b1;
                     if (dec.op7.hlt) halted <= 1'b1;
                  end else if (unsupported_count != '1) begin
                     unsupported_count <= unsupported_count + 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               base_addr      <= '0;
               pdp_mem_opcode <= '0;
               pdp_op7_opcode <= '0;
               issue_pulse    <= 1'b0;
               state          <= ST_WAIT;
            end
            // Exec cannot have raised stall yet, so this cycle never samples it;
            // a busy exec is honoured by the stall gate on the next pop in IDLE.
            ST_WAIT: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_instr_feeder.sv
// Directed bench for exec_instr_feeder: expected issues are queued when words are
// pushed and checked by a monitor whenever issue_pulse is seen.
module tb_exec_instr_feeder;
   import pdp8_pkg::*;

   localparam int FIFO_DEPTH = 8;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            load_valid = 1'b0;
   logic [11:0]     load_data = '0;
   logic            stall = 1'b0;
   logic [11:0]     pc_value = '0;
   logic            load_ready;
   logic [3:0]      fifo_count;
   logic [11:0]     base_addr;
   pdp_mem_opcode_s pdp_mem_opcode;
   pdp_op7_opcode_s pdp_op7_opcode;
   logic            issue_pulse;
   logic [15:0]     issued_count;
   logic [7:0]      unsupported_count;
   logic            halted;
   logic            overflow;
   feeder_state_e   fsm_state;

   int checks = 0;
   int failures = 0;
   int issue_seen = 0;
   int exp_issued = 0;
   logic [32:0] exp_q[$];

   exec_instr_feeder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .load_valid        (load_valid),
      .load_data         (load_data),
      .load_ready        (load_ready),
      .fifo_count        (fifo_count),
      .stall             (stall),
      .PC_value          (pc_value),
      .base_addr         (base_addr),
      .pdp_mem_opcode    (pdp_mem_opcode),
      .pdp_op7_opcode    (pdp_op7_opcode),
      .issue_pulse       (issue_pulse),
      .issued_count      (issued_count),
      .unsupported_count (unsupported_count),
      .halted            (halted),
      .overflow          (overflow),
      .fsm_state         (fsm_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [11:0] w);
      load_valid = 1'b1;
      load_data  = w;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic expect_issue(input pdp_mem_opcode_s m, input pdp_op7_opcode_s o, input logic [11:0] b);
      exp_q.push_back({m, o, b});
      exp_issued++;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      repeat (4) tick();
      check("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic wait_issue(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (issue_pulse) break;
         tick();
      end
      check("wait_issue", 64'(issue_pulse), 64'(1));
   endtask

   task automatic check_nop(input string tag);
      check(tag, 64'({pdp_mem_opcode, pdp_op7_opcode, base_addr, issue_pulse}), 64'(0));
   endtask

   always @(negedge clk) begin
      logic [32:0] e;
      if (reset_n) begin
         if (issue_pulse) begin
            issue_seen++;
            check("issue_has_expect", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("issue_mem", 64'(pdp_mem_opcode), 64'(e[32:26]));
               check("issue_op7", 64'(pdp_op7_opcode), 64'(e[25:12]));
               check("issue_base", 64'(base_addr), 64'(e[11:0]));
            end
         end else begin
            check("idle_nop", 64'({pdp_mem_opcode, pdp_op7_opcode, base_addr}), 64'(0));
         end
      end
   end

   initial begin
      pdp_mem_opcode_s m;
      pdp_op7_opcode_s o;
      int seen_before;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_load_ready", 64'(load_ready), 64'(1));
      check("rst_fifo_count", 64'(fifo_count), 64'(0));
      check("rst_counters", 64'({issued_count, unsupported_count}), 64'(0));
      check("rst_flags", 64'({halted, overflow}), 64'(0));
      check_nop("rst_nop");
      reset_n = 1'b1;
      tick();

      // TAD page zero
      m = '0; m.tad = 1'b1; o = '0;
      expect_issue(m, o, 12'o0105);
      push_word(12'o1105);
      drain(20);
      check("issued_after_tad", 64'(issued_count), 64'(exp_issued));

      // Current-page TAD, then indirect JMP on page zero
      pc_value = 12'o2200;
      m = '0; m.tad = 1'b1; o = '0;
      expect_issue(m, o, 12'o2305);
      push_word(12'o1305);
      m = '0; m.jmp = 1'b1; m.indirect = 1'b1;
      expect_issue(m, o, 12'o0105);
      push_word(12'o5505);
      drain(20);

      // IOT dropped, IAC issued the cycle after the drop
      m = '0; o = '0; o.iac = 1'b1;
      expect_issue(m, o, 12'o0000);
      push_word(12'o6001);
      push_word(12'o7001);
      tick();
      check("iac_after_drop", 64'(issue_pulse), 64'(1));
      check("unsupported_one", 64'(unsupported_count), 64'(1));
      drain(20);

      // Stall held across an issue with three words queued
      stall = 1'b1;
      o = '0;
      for (int i = 1; i <= 4; i++) begin
         m = '0; m.tad = 1'b1;
         expect_issue(m, o, 12'(i));
         push_word(12'o1000 + 12'(i));
      end
      check("stalled_count", 64'(fifo_count), 64'(4));
      seen_before = issue_seen;
      stall = 1'b0;
      wait_issue(10);
      stall = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("stall_no_issue", 64'(issue_seen), 64'(seen_before + 1));
      check("stall_queue", 64'(fifo_count), 64'(3));
      stall = 1'b0;
      tick();
      check("issue_after_stall", 64'(issue_pulse), 64'(1));
      drain(30);
      check("stall_all_issued", 64'(issue_seen), 64'(seen_before + 4));

      // Group 1 CLA CLL, then HLT blocks the trailing TAD
      m = '0; o = '0; o.cla = 1'b1; o.cll = 1'b1;
      expect_issue(m, o, 12'o0000);
      push_word(12'o7300);
      o = '0; o.hlt = 1'b1;
      expect_issue(m, o, 12'o0000);
      push_word(12'o7402);
      push_word(12'o1105);
      drain(30);
      repeat (10) tick();
      check("halted_set", 64'(halted), 64'(1));
      check("halted_fifo_count", 64'(fifo_count), 64'(1));
      check("issued_total", 64'(issued_count), 64'(exp_issued));

      // Fill to full with stall, overflow on the ninth push, then async reset
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      exp_q.delete();
      exp_issued = 0;
      check("halted_cleared", 64'(halted), 64'(0));
      stall = 1'b1;
      for (int i = 0; i < 8; i++) push_word(12'o1000 + 12'(i));
      check("full_load_ready", 64'(load_ready), 64'(0));
      check("full_count", 64'(fifo_count), 64'(8));
      check("full_no_overflow", 64'(overflow), 64'(0));
      push_word(12'o1010);
      check("overflow_set", 64'(overflow), 64'(1));
      check("overflow_count", 64'(fifo_count), 64'(8));
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_count", 64'(fifo_count), 64'(0));
      check("async_rst_overflow", 64'(overflow), 64'(0));
      check("async_rst_ready", 64'(load_ready), 64'(1));
      check_nop("async_rst_nop");
      tick();
      reset_n = 1'b1;
      stall = 1'b0;
      tick();

      // Reset in the middle of an ISSUE cycle
      m = '0; m.tad = 1'b1; o = '0;
      expect_issue(m, o, 12'o0105);
      push_word(12'o1105);
      wait_issue(10);
      check("mid_issue_base", 64'(base_addr), 64'(12'o0105));
      reset_n = 1'b0;
      #1;
      check_nop("mid_issue_rst_nop");
      check("mid_issue_rst_count", 64'({issued_count, fifo_count}), 64'(0));
      exp_q.delete();
      tick();
      reset_n = 1'b1;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exec_instr_feeder.md
Name: exec_instr_feeder

Overview:
Instruction-issue initiator toward instr_exec. It replaces instr_decode in unit-level execution benches and can serve as an alternate front end at system level. The bench or a loader pushes raw 12-bit PDP-8 words into an internal FIFO. The block decodes each word into base_addr, pdp_mem_opcode and pdp_op7_opcode, and issues it under the stall handshake, tracking PC_value for current-page addressing.

Parameters:
FIFO_DEPTH, 8, instruction FIFO entries (power of 2, >=2)
ADDR_WIDTH, `ADDR_WIDTH (12), address width
DATA_WIDTH, `DATA_WIDTH (12), instruction word width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
load_valid  in  1  push load_data into FIFO
load_data  in  DATA_WIDTH  raw PDP-8 instruction word
load_ready  out  1  FIFO not full
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
stall  in  1  execution unit busy
PC_value  in  ADDR_WIDTH  current PC from execution unit
base_addr  out  ADDR_WIDTH  effective (pre-indirection) operand address
pdp_mem_opcode  out  pdp8_pkg::pdp_mem_opcode_s  memory-reference opcode fields
pdp_op7_opcode  out  pdp8_pkg::pdp_op7_opcode_s  group-1/group-2 operate fields
issue_pulse  out  1  high during the single issue cycle
issued_count  out  16  instructions issued, saturating
unsupported_count  out  8  IOT/group-3 words dropped, saturating
halted  out  1  sticky, set when HLT issued
overflow  out  1  sticky, push attempted while full

Behaviour:
- Reset (async): FIFO empty, state IDLE, all opcode struct fields 0 (NOP), base_addr 0, all counters and flags 0, load_ready 1.
- FIFO push: load_valid && load_ready. load_valid while full is dropped and sets overflow.
- FIFO pop: occurs only in IDLE. No same-cycle pass-through when empty; a word pushed at edge N is poppable at edge N+1 at the earliest.
- FSM states:
  - IDLE: if FIFO non-empty && !stall && !halted, pop and decode; go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): outputs hold the decoded instruction; issue_pulse=1; issued_count++. Go to WAIT.
  - WAIT: outputs return to NOP. The first WAIT cycle ignores stall (exec stall latency). Afterwards, leave for IDLE when stall=0.
- Issue latency: pop edge N, outputs valid cycle N+1. Minimum issue spacing is 3 cycles.
- Decode of word w, PDP bit 0 = MSB:
  - Opcode w[11:9] in 0..5 (AND, TAD, ISZ, DCA, JMS, JMP): set the one-hot mnemonic field and indirect field = w[8]. base_addr = w[7] ? {PC_value[11:7], w[6:0]} : {5'b0, w[6:0]}. PC_value is sampled at the pop edge.
  - Opcode 7 with w[8]=0 (group 1): CLA=w7, CLL=w6, CMA=w5, CML=w4, RAR=w3, RAL=w2, rotate-twice=w1, IAC=w0.
  - Opcode 7 with w[8]=1 and w[0]=0 (group 2): SMA/SPA=w6, SZA/SNA=w5, SNL/SZL=w4, sense reversal=w3, CLA=w7, OSR=w2, HLT=w1. base_addr=0 for all operate words.
  - Opcode 6, or opcode 7 with w[8]=w[0]=1: no issue. The word is consumed, unsupported_count++, FSM stays in IDLE (no ISSUE cycle), and the next pop is allowed next cycle.
- HLT issue sets halted. Further pops are blocked and the FIFO retains its contents. Only reset clears halted.
- stall rising during ISSUE has no effect on the current instruction. Counters saturate with no wrap.
- Reset asserted mid-ISSUE or mid-WAIT: outputs go to NOP immediately and the FIFO is flushed.

Decomposition:
- pdp8_pkg (existing) owns pdp_mem_opcode_s and pdp_op7_opcode_s, plus opcode constants OP_AND..OP_OPR and a pure function decode_word(word, pc) returning the structs and base_addr. The checker and scoreboard reuse this function.
- One sub-module, instr_word_fifo: synchronous FIFO with async reset, parameterised by depth and width, providing count/full/empty.

Test Plan:
- Push 0o1105 (TAD, page zero) with stall=0 -> one cycle with tad=1, indirect=0, base_addr=0o0105, issue_pulse=1; issued_count=1.
- PC_value=0o2200, push 0o1305 (TAD, current page) -> base_addr=0o2305. Push 0o5505 -> jmp=1, indirect=1, base_addr=0o0105.
- Push 0o7300, then 0o7402, then 0o1105 -> first issue has group-1 CLA=1, CLL=1. Second is HLT and halted=1. 0o1105 is never issued; fifo_count=1.
- Push 0o6001 then 0o7001 -> unsupported_count=1, no issue for 0o6001. IAC is issued the cycle after the drop.
- Hold stall=1 for 10 cycles after an issue with 3 words queued -> no issue_pulse until 1 cycle after stall falls; each word is issued exactly once.
- Push 9 words with stall=1 (FIFO_DEPTH=8) -> load_ready=0 after the 8th push; overflow=1; fifo_count=8. Assert reset_n=0 -> count=0, all outputs NOP, overflow=0.
